// File: rtl/core_pkg.sv
// Shared encodings for the compute core: scheduler and fetcher states,
// plus the saturating performance-counter helper.
package core_pkg;

  // Scheduler state encodings, shared with the core scheduler.
  localparam logic [2:0] CORE_IDLE    = 3'b000;
  localparam logic [2:0] CORE_FETCH   = 3'b001;
  localparam logic [2:0] CORE_DECODE  = 3'b010;
  localparam logic [2:0] CORE_REQUEST = 3'b011;
  localparam logic [2:0] CORE_WAIT    = 3'b100;
  localparam logic [2:0] CORE_EXECUTE = 3'b101;
  localparam logic [2:0] CORE_UPDATE  = 3'b110;
  localparam logic [2:0] CORE_DONE    = 3'b111;

  // Fetcher state encodings, observed by the scheduler.
  localparam logic [2:0] FETCHER_IDLE     = 3'b000;
  localparam logic [2:0] FETCHER_FETCHING = 3'b001;
  localparam logic [2:0] FETCHER_FETCHED  = 3'b010;

  localparam int unsigned PERF_CNT_BITS = 16;

  typedef logic [PERF_CNT_BITS-1:0] perf_cnt_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic perf_cnt_t sat_inc(input perf_cnt_t v);
    return (v == '1) ? v : v + perf_cnt_t'(1);
  endfunction

endpackage

// File: rtl/icache_array.sv
// Direct-mapped instruction cache storage: one-word lines with valid bit
// and tag. Asynchronous read port, single write port, global flush.
module icache_array
  import core_pkg::*;
#(
  parameter  int unsigned LINES     = 8,
  parameter  int unsigned TAG_BITS  = 5,
  parameter  int unsigned DATA_BITS = 32,
  localparam int unsigned IDX_BITS  = $clog2(LINES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush_i,
  input  logic [IDX_BITS-1:0]  rd_index_i,
  output logic                 rd_valid_o,
  output logic [TAG_BITS-1:0]  rd_tag_o,
  output logic [DATA_BITS-1:0] rd_data_o,
  input  logic                 wr_en_i,
  input  logic [IDX_BITS-1:0]  wr_index_i,
  input  logic [TAG_BITS-1:0]  wr_tag_i,
  input  logic [DATA_BITS-1:0] wr_data_i
);

  logic [LINES-1:0]     valid_q;
  logic [TAG_BITS-1:0]  tag_q  [LINES];
  logic [DATA_BITS-1:0] data_q [LINES];

  // Valid bits: reset and flush clear all lines; flush beats a same-cycle fill.
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_index_i] <= 1'b1;
    end
  end

  // Tag and data payload; only meaningful while the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en_i && !flush_i && !reset) begin
      tag_q[wr_index_i]  <= wr_tag_i;
      data_q[wr_index_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_data_o  = data_q[rd_index_i];

endmodule

// File: rtl/instr_fetcher.sv
// Instruction fetch stage: looks up current_pc in a direct-mapped icache,
// fills from program memory over valid/ready on a miss, and reports
// progress to the scheduler via fetcher_state. All outputs are registered.
module instr_fetcher
  import core_pkg::*;
#(
  parameter int unsigned PROGRAM_MEM_ADDR_BITS = 8,
  parameter int unsigned PROGRAM_MEM_DATA_BITS = 32,
  parameter int unsigned CACHE_LINES           = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  input  logic                             flush,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  output logic [15:0]                      hit_count,
  output logic [15:0]                      miss_count
);

  localparam int unsigned IDX_BITS = $clog2(CACHE_LINES);
  localparam int unsigned TAG_BITS = PROGRAM_MEM_ADDR_BITS - IDX_BITS;

  logic [2:0]                       state_q,     state_d;
  logic                             mem_valid_q, mem_valid_d;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_addr_q,  mem_addr_d;
  logic [PROGRAM_MEM_DATA_BITS-1:0] instr_q,     instr_d;
  perf_cnt_t                        hit_cnt_q,   hit_cnt_d;
  perf_cnt_t                        miss_cnt_q,  miss_cnt_d;

  logic                             fill_en;
  logic                             rd_valid;
  logic [TAG_BITS-1:0]              rd_tag;
  logic [PROGRAM_MEM_DATA_BITS-1:0] rd_data;
  logic                             lookup_hit;

  logic [IDX_BITS-1:0] pc_index;
  logic [TAG_BITS-1:0] pc_tag;

  assign pc_index = current_pc[IDX_BITS-1:0];
  assign pc_tag   = current_pc[PROGRAM_MEM_ADDR_BITS-1:IDX_BITS];

  // The fill uses the latched request address so a PC change mid-miss
  // cannot install the returned word under the wrong line.
  icache_array #(
    .LINES     (CACHE_LINES),
    .TAG_BITS  (TAG_BITS),
    .DATA_BITS (PROGRAM_MEM_DATA_BITS)
  ) u_icache (
    .clk        (clk),
    .reset      (reset),
    .flush_i    (flush),
    .rd_index_i (pc_index),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .wr_en_i    (fill_en && !reset),
    .wr_index_i (mem_addr_q[IDX_BITS-1:0]),
    .wr_tag_i   (mem_addr_q[PROGRAM_MEM_ADDR_BITS-1:IDX_BITS]),
    .wr_data_i  (mem_read_data)
  );

  assign lookup_hit = rd_valid && (rd_tag == pc_tag);

  // Fetch FSM next-state, memory request, instruction latch and counters.
  always_comb begin
    state_d     = state_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    instr_d     = instr_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    fill_en     = 1'b0;
    case (state_q)
      FETCHER_IDLE: begin
        if (core_state == CORE_FETCH) begin
          if (lookup_hit) begin
            instr_d   = rd_data;
            hit_cnt_d = sat_inc(hit_cnt_q);
            state_d   = FETCHER_FETCHED;
          end else begin
            mem_valid_d = 1'b1;
            mem_addr_d  = current_pc;
            miss_cnt_d  = sat_inc(miss_cnt_q);
            state_d     = FETCHER_FETCHING;
          end
        end
      end
      FETCHER_FETCHING: begin
        if (mem_read_ready) begin
          instr_d     = mem_read_data;
          fill_en     = 1'b1;
          mem_valid_d = 1'b0;
          state_d     = FETCHER_FETCHED;
        end
      end
      FETCHER_FETCHED: begin
        if (core_state == CORE_DECODE) begin
          state_d = FETCHER_IDLE;
        end
      end
      default: begin
        state_d     = FETCHER_IDLE;
        mem_valid_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FETCHER_IDLE;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      instr_q     <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      instr_q     <= instr_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  assign fetcher_state    = state_q;
  assign mem_read_valid   = mem_valid_q;
  assign mem_read_address = mem_addr_q;
  assign instruction      = instr_q;
  assign hit_count        = hit_cnt_q;
  assign miss_count       = miss_cnt_q;

endmodule

// File: doc/instr_fetcher.md
# instr_fetcher

Instruction fetch stage for one compute core. It sits directly upstream of the core scheduler: it watches `core_state`, fetches the instruction at `current_pc`, and reports progress on `fetcher_state`. Fetches are served from a small direct-mapped instruction cache. On a miss it performs a valid/ready read from program memory and installs the returned word. The scheduler advances from FETCH to DECODE when it sees `fetcher_state == FETCHED`.

## Interface
- `PROGRAM_MEM_ADDR_BITS`, 8, PC / program memory address width.
- `PROGRAM_MEM_DATA_BITS`, 32, instruction word width.
- `CACHE_LINES`, 8, number of one-word cache lines; power of two, ≥2.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `core_state`  in  3  scheduler state (FETCH = 3'b001, DECODE = 3'b010).
- `current_pc`  in  PROGRAM_MEM_ADDR_BITS  address of the instruction to fetch.
- `flush`  in  1  invalidates all cache lines (kernel reload).
- `mem_read_valid`  out  1  program memory read request.
- `mem_read_address`  out  PROGRAM_MEM_ADDR_BITS  request address.
- `mem_read_ready`  in  1  memory response strobe; data valid this cycle.
- `mem_read_data`  in  PROGRAM_MEM_DATA_BITS  response data.
- `fetcher_state`  out  3  IDLE = 3'b000, FETCHING = 3'b001, FETCHED = 3'b010.
- `instruction`  out  PROGRAM_MEM_DATA_BITS  fetched instruction, held until the next fetch completes.
- `hit_count`, `miss_count`  out  16 each  saturating performance counters.

## Operation
- Address split: index = `current_pc[log2(CACHE_LINES)-1:0]`; tag = the remaining upper PC bits.
- Per line: valid bit, tag, and data word.
- **IDLE** with `core_state == FETCH`, on a hit:
  - `instruction` <= line data.
  - `hit_count` increments.
  - next state FETCHED.
- **IDLE** with `core_state == FETCH`, on a miss:
  - `mem_read_valid` <= 1, `mem_read_address` <= `current_pc`.
  - `miss_count` increments.
  - next state FETCHING.
- **FETCHING**:
  - `mem_read_valid` and `mem_read_address` are held stable until `mem_read_ready`.
  - When `mem_read_ready` arrives: `instruction` <= `mem_read_data`, the line is written (valid = 1, tag, data), `mem_read_valid` <= 0, next state FETCHED.
  - `mem_read_ready` is ignored in any other state.
- **FETCHED**: when `core_state == DECODE`, next state IDLE. Otherwise remain in FETCHED.
- **flush**:
  - Clears every valid bit the same cycle.
  - If it coincides with a fill, flush wins: the line is not installed, but `instruction` is still captured and FETCHED is still reached.
  - Flush in IDLE does not alter a lookup in that cycle; the lookup uses the pre-flush valid bits.
- Counters saturate at 16'hFFFF and are cleared only by reset.
- **Reset** (any state, including mid-miss):
  - All valid bits 0.
  - `fetcher_state` = IDLE, `mem_read_valid` = 0, `mem_read_address` = 0, `instruction` = 0, both counters 0.
  - An outstanding memory response arriving after reset is ignored.

## Timing
- Hit: `core_state == FETCH` sampled at edge N gives FETCHED visible after edge N. Scheduler DECODE follows one cycle later.
- Miss: `mem_read_valid` is high after edge N. Ready sampled at edge M gives FETCHED after edge M. Minimum miss latency is 2 cycles (ready in the first cycle valid is seen).
- FETCHED → IDLE happens on the edge where DECODE is sampled, one cycle after FETCHED.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package `core_pkg`:
  - `core_state` encodings (IDLE…DONE, 3-bit), shared with the scheduler.
  - `fetcher_state` encodings.
- Sub-module `icache_array`: valid/tag/data storage with one read port (index → valid, tag, data), one write port, and a flush input. The fetcher FSM and counters live in `instr_fetcher`.

## Test plan
- Cold miss:
  - Stimulus: reset, then `core_state` = FETCH with PC 0x05; memory returns 0xDEADBEEF after 3 cycles.
  - Required: `mem_read_valid` = 1 with address 0x05 until ready; then FETCHED, `instruction` = 0xDEADBEEF, `miss_count` = 1.
- Hit:
  - Stimulus: refetch PC 0x05.
  - Required: FETCHED one cycle after FETCH, no `mem_read_valid`, `hit_count` = 1.
- Conflict:
  - Stimulus: fetch 0x0D (same index as 0x05, different tag), then 0x05.
  - Required: both miss; `miss_count` = 3.
- Flush during fill:
  - Stimulus: `flush` asserted in the same cycle as `mem_read_ready` for PC 0x07, then refetch 0x07.
  - Required: `instruction` is correct on the first fetch; the refetch misses.
- Reset mid-miss:
  - Stimulus: reset while in FETCHING, then a late `mem_read_ready`.
  - Required: IDLE, `mem_read_valid` = 0, no cache update, counters 0.
- Saturation:
  - Stimulus: force 65540 hits.
  - Required: `hit_count` = 16'hFFFF.
